// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles big-endian words into instruction memory and holds the core in reset while loading.
// Optional running-XOR checksum of written words is built when IMEM_LOADER_CKSUM_EN is defined.
module imem_loader #(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   word_count
`ifdef IMEM_LOADER_CKSUM_EN
  ,
  input  logic [31:0]       cksum_exp,
  output logic [31:0]       cksum
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DRAIN, RUN} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W:0]   CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};

  state_t              state_q, state_d;
  logic [31:0]         word_q, word_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                last_q, last_d;
  logic                err_q, err_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic [31:0]         shifted;
  logic                accept;
  logic                start;
  logic                cksum_ok;

  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  // Left-justify a short final word: n is the count of bytes already held before the last one.
  function automatic logic [31:0] justify(input logic [31:0] w, input logic [1:0] n);
    case (n)
      2'd0:    return {w[7:0], 24'h0};
      2'd1:    return {w[15:0], 16'h0};
      2'd2:    return {w[23:0], 8'h0};
      default: return w;
    endcase
  endfunction

  assign shifted = {word_q[23:0], s_data};
  assign accept  = s_valid & s_ready;
  assign start   = ((state_q == IDLE) || (state_q == RUN)) && load_req;

`ifdef IMEM_LOADER_CKSUM_EN
  logic [31:0] cksum_q, cksum_d;
  // The final word is not yet folded into cksum_q during its WRITE cycle.
  assign cksum_ok = ((cksum_q ^ word_q) == cksum_exp);
  assign cksum    = cksum_q;
`else
  assign cksum_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, RUN: if (load_req) state_d = LOAD;
      LOAD:      if (accept && (s_last || byte_cnt_q == 2'd3)) state_d = WRITE;
      WRITE: begin
        if (last_q)                  state_d = cksum_ok ? RUN : IDLE;
        else if (addr_q == ADDR_MAX) state_d = DRAIN;
        else                         state_d = LOAD;
      end
      DRAIN:     if (accept && s_last) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready    = (state_q == LOAD) || (state_q == DRAIN);
    imem_we    = (state_q == WRITE);
    core_rst   = (state_q != RUN);
    busy       = (state_q == LOAD) || (state_q == WRITE) || (state_q == DRAIN);
    imem_addr  = addr_q;
    imem_wdata = word_q;
    err        = err_q;
    word_count = word_count_q;
  end

  always_comb begin
    word_d       = word_q;
    byte_cnt_d   = byte_cnt_q;
    addr_d       = addr_q;
    last_d       = last_q;
    err_d        = err_q;
    word_count_d = word_count_q;
`ifdef IMEM_LOADER_CKSUM_EN
    cksum_d      = cksum_q;
`endif
    if (start) begin
      byte_cnt_d   = '0;
      addr_d       = BASE_ADDR;
      last_d       = 1'b0;
      err_d        = 1'b0;
      word_count_d = '0;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum_d      = '0;
`endif
    end
    if (state_q == LOAD && accept) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      if (s_last) begin
        last_d = 1'b1;
        word_d = justify(shifted, byte_cnt_q);
        if (byte_cnt_q != 2'd3) err_d = 1'b1;
      end else begin
        word_d = shifted;
      end
    end
    if (state_q == WRITE) begin
      addr_d       = addr_q + 1'b1;
      word_count_d = sat_inc(word_count_q);
      byte_cnt_d   = '0;
      if (!last_q && addr_q == ADDR_MAX) err_d = 1'b1;
      if (last_q && !cksum_ok)           err_d = 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum_d      = cksum_q ^ word_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q       <= '0;
      byte_cnt_q   <= '0;
      addr_q       <= BASE_ADDR;
      last_q       <= 1'b0;
      err_q        <= 1'b0;
      word_count_q <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum_q      <= '0;
`endif
    end else begin
      word_q       <= word_d;
      byte_cnt_q   <= byte_cnt_d;
      addr_q       <= addr_d;
      last_q       <= last_d;
      err_q        <= err_d;
      word_count_q <= word_count_d;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum_q      <= cksum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized program loads against a word-level reference model.
module tb_imem_loader;
  localparam int             AW   = 3;
  localparam logic [AW-1:0]  BASE = 3'd2;
  localparam int             CAP  = (1 << AW) - 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_req = 1'b0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = 8'h0;
  logic          s_last = 1'b0;
  logic          s_ready, imem_we, core_rst, busy, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   word_count;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [31:0]   cksum_exp = 32'h0;
  logic [31:0]   cksum;
`endif

  imem_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .load_req(load_req),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .busy(busy), .err(err), .word_count(word_count)
`ifdef IMEM_LOADER_CKSUM_EN
    , .cksum_exp(cksum_exp), .cksum(cksum)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int we_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      we_cnt++;
      chk("ready_low_in_write", {31'h0, s_ready}, 32'h0);
    end
  end

  // Word k of a program: four bytes big-endian, missing tail bytes read as zero.
  function automatic logic [31:0] exp_word(input logic [7:0] p[$], input int k);
    logic [31:0] w;
    w = 32'h0;
    for (int j = 0; j < 4; j++) begin
      w = w << 8;
      if (4 * k + j < p.size()) w[7:0] = p[4 * k + j];
    end
    return w;
  endfunction

  function automatic logic [31:0] prog_xor(input logic [7:0] p[$]);
    logic [31:0] x;
    int nw;
    x  = 32'h0;
    nw = (p.size() + 3) / 4;
    if (nw > CAP) nw = CAP;
    for (int k = 0; k < nw; k++) x = x ^ exp_word(p, k);
    return x;
  endfunction

  task automatic start_load();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    chk("load_busy", {31'h0, busy}, 32'h1);
    chk("load_err_clr", {31'h0, err}, 32'h0);
    chk("load_wc_clr", {28'h0, word_count}, 32'h0);
    chk("load_core_held", {31'h0, core_rst}, 32'h1);
    chk("load_addr", {29'h0, imem_addr}, {29'h0, BASE});
  endtask

  // Present one byte and hold it until accepted; returns 0 if never accepted.
  task automatic send_byte(input logic [7:0] b, input logic last, output bit acc);
    s_valid = 1'b1;
    s_data  = b;
    s_last  = last;
    acc     = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'($urandom);
  endtask

  task automatic run_load(input logic [7:0] prog[$], input int gmode, input logic [31:0] cexp);
    int nb, nw, exp_wr, we0, gap, k;
    bit ovf, ck_ok, run_end, err_exp, acc;
    logic [31:0] x;
    nb      = prog.size();
    nw      = (nb + 3) / 4;
    ovf     = (nw > CAP);
    exp_wr  = ovf ? CAP : nw;
    x       = prog_xor(prog);
    ck_ok   = 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
    ck_ok     = (x == cexp);
    cksum_exp = cexp;
`endif
    run_end = !ovf && ck_ok;
    err_exp = ovf || (nb % 4 != 0) || !ck_ok;
    we0     = we_cnt;
    start_load();
    for (int i = 0; i < nb; i++) begin
      gap = (gmode == 0) ? 0 : (gmode == 1) ? 1 : int'($urandom_range(0, 3));
      repeat (gap) begin
        s_valid  = 1'b0;
        load_req = ($urandom_range(0, 3) == 0);
        @(posedge clk); #1;
      end
      load_req = 1'b0;
      send_byte(prog[i], (i == nb - 1), acc);
      if (!acc) begin
        chk("accept_timeout", 32'h0, 32'h1);
        return;
      end
      k = i / 4;
      if (k < CAP && (i % 4 == 3 || i == nb - 1)) begin
        chk("we_latency", {31'h0, imem_we}, 32'h1);
        chk("wr_addr", {29'h0, imem_addr}, 32'(BASE) + 32'(k));
        chk("wr_data", imem_wdata, exp_word(prog, k));
      end
    end
    if (run_end) begin
      chk("final_write_core_held", {31'h0, core_rst}, 32'h1);
      @(posedge clk); #1;
      chk("run_core_released", {31'h0, core_rst}, 32'h0);
    end else if (ovf) begin
      chk("drain_core_held", {31'h0, core_rst}, 32'h1);
    end else begin
      @(posedge clk); #1;
      chk("ck_fail_core_held", {31'h0, core_rst}, 32'h1);
    end
    chk("end_busy", {31'h0, busy}, 32'h0);
    chk("end_ready", {31'h0, s_ready}, 32'h0);
    chk("end_err", {31'h0, err}, {31'h0, err_exp});
    chk("end_word_count", {28'h0, word_count}, 32'(exp_wr));
    chk("we_pulses", 32'(we_cnt - we0), 32'(exp_wr));
`ifdef IMEM_LOADER_CKSUM_EN
    chk("cksum", cksum, x);
`endif
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_core_rst"}, {31'h0, core_rst}, 32'h1);
    chk({tag, "_s_ready"}, {31'h0, s_ready}, 32'h0);
    chk({tag, "_imem_we"}, {31'h0, imem_we}, 32'h0);
    chk({tag, "_addr"}, {29'h0, imem_addr}, {29'h0, BASE});
    chk({tag, "_wdata"}, imem_wdata, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_err"}, {31'h0, err}, 32'h0);
    chk({tag, "_wc"}, {28'h0, word_count}, 32'h0);
  endtask

  initial begin
    logic [7:0] p[$];
    bit acc;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("idle");

    p = {8'h00, 8'h00, 8'h00, 8'h01, 8'h3F, 8'hFF, 8'hFF, 8'hFF};
    run_load(p, 0, 32'h3FFFFFFE);

    p = {8'hAA, 8'hBB};
    run_load(p, 0, 32'hAABB0000);

    p = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    run_load(p, 1, 32'h11223344 ^ 32'h55667788 ^ 32'h99AABBCC);

    p = {};
    for (int i = 0; i < 30; i++) p.push_back(8'(i + 1));
    run_load(p, 2, prog_xor(p));

    start_load();
    for (int i = 0; i < 6; i++) begin
      send_byte(8'(8'hC0 + i), 1'b0, acc);
      if (!acc) chk("rst_test_accept", 32'h0, 32'h1);
    end
    #2 rst = 1'b0;
    #1;
    chk_reset_vals("midload_rst");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    p = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_load(p, 0, 32'hDEADBEEF);

`ifdef IMEM_LOADER_CKSUM_EN
    p = {8'h12, 8'h34, 8'h56, 8'h78, 8'h0F, 8'h0F, 8'h0F, 8'h0F};
    run_load(p, 0, 32'h1D3B5977);
    run_load(p, 0, 32'h0);
`endif

    for (int r = 0; r < 20; r++) begin
      int nb;
      logic [31:0] ce;
      nb = int'($urandom_range(1, 32));
      p  = {};
      for (int i = 0; i < nb; i++) p.push_back(8'($urandom));
      ce = ($urandom_range(0, 3) == 0) ? (prog_xor(p) ^ 32'h1) : prog_xor(p);
      run_load(p, int'($urandom_range(0, 2)), ce);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
